// File: rtl/conv1_maxpool_stage.sv
// conv1 2x2 stride-2 max-pool: even rows fill a per-filter line buffer, odd rows pool against it.
// Latency 1 on odd rows; single-entry output register with skid-style ready. Optional ReLU: CONV1_POOL_RELU_EN.
module conv1_maxpool_stage #(
  parameter int NUM_FILT     = 6,
  parameter int PXL_PER_BEAT = 4,
  parameter int IN_WIDTH     = 22,
  parameter int FMAP_WIDTH   = 28,
  parameter int FMAP_HEIGHT  = 28
) (
  input  logic                                         pool1_clk,
  input  logic                                         pool1_rst,
  input  logic                                         pool1_in_valid_i,
  output logic                                         pool1_in_ready_o,
  input  logic [NUM_FILT*PXL_PER_BEAT*IN_WIDTH-1:0]     pool1_in_data_i,
  output logic                                         pool1_out_valid_o,
  input  logic                                         pool1_out_ready_i,
  output logic [NUM_FILT*(PXL_PER_BEAT/2)*IN_WIDTH-1:0] pool1_out_data_o,
  output logic                                         pool1_out_last_o
);

  localparam int HALF     = PXL_PER_BEAT / 2;
  localparam int COLS     = FMAP_WIDTH / PXL_PER_BEAT;
  localparam int CW       = (COLS > 1) ? $clog2(COLS) : 1;
  localparam int RW       = (FMAP_HEIGHT > 1) ? $clog2(FMAP_HEIGHT) : 1;
  localparam int OUT_BITS = NUM_FILT * HALF * IN_WIDTH;

  logic [CW-1:0]       col_q, col_d;
  logic [RW-1:0]       row_q, row_d;
  logic                out_vld_q, out_vld_d;
  logic                out_last_q, out_last_d;
  logic [OUT_BITS-1:0] out_dat_q, out_dat_d;
  logic [OUT_BITS-1:0] linebuf_q [COLS];
  logic [OUT_BITS-1:0] h_dat, v_dat;
  logic signed [IN_WIDTH-1:0] h_tmp, v_tmp;
  logic odd_row, last_col, last_row, in_fire;

  function automatic logic signed [IN_WIDTH-1:0] smax(input logic signed [IN_WIDTH-1:0] a,
                                                       input logic signed [IN_WIDTH-1:0] b);
    return (a > b) ? a : b;
  endfunction

  assign odd_row  = row_q[0];
  assign last_col = (col_q == CW'(COLS - 1));
  assign last_row = (row_q == RW'(FMAP_HEIGHT - 1));

  // Even rows never produce output, so they are only held off by reset.
  assign pool1_in_ready_o = !pool1_rst && (!odd_row || !out_vld_q || pool1_out_ready_i);
  assign in_fire          = pool1_in_valid_i && pool1_in_ready_o;

  always_comb begin
    h_dat = '0;
    v_dat = '0;
    h_tmp = '0;
    v_tmp = '0;
    for (int f = 0; f < NUM_FILT; f++) begin
      for (int k = 0; k < HALF; k++) begin
        h_tmp = smax(pool1_in_data_i[(f*PXL_PER_BEAT + 2*k)*IN_WIDTH +: IN_WIDTH],
                     pool1_in_data_i[(f*PXL_PER_BEAT + 2*k + 1)*IN_WIDTH +: IN_WIDTH]);
        v_tmp = smax(h_tmp, linebuf_q[col_q][(f*HALF + k)*IN_WIDTH +: IN_WIDTH]);
`ifdef CONV1_POOL_RELU_EN
        if (v_tmp[IN_WIDTH-1]) v_tmp = '0;
`endif
        h_dat[(f*HALF + k)*IN_WIDTH +: IN_WIDTH] = h_tmp;
        v_dat[(f*HALF + k)*IN_WIDTH +: IN_WIDTH] = v_tmp;
      end
    end
  end

  always_comb begin
    col_d      = col_q;
    row_d      = row_q;
    out_vld_d  = out_vld_q;
    out_last_d = out_last_q;
    out_dat_d  = out_dat_q;
    if (out_vld_q && pool1_out_ready_i) begin
      out_vld_d  = 1'b0;
      out_last_d = 1'b0;
    end
    if (in_fire) begin
      if (last_col) begin
        col_d = '0;
        row_d = last_row ? '0 : row_q + 1'b1;
      end else begin
        col_d = col_q + 1'b1;
      end
      // A new odd-row result overrides any same-cycle drain of the register.
      if (odd_row) begin
        out_vld_d  = 1'b1;
        out_dat_d  = v_dat;
        out_last_d = last_row && last_col;
      end
    end
  end

  always_ff @(posedge pool1_clk) begin
    if (pool1_rst) begin
      col_q      <= '0;
      row_q      <= '0;
      out_vld_q  <= 1'b0;
      out_last_q <= 1'b0;
      out_dat_q  <= '0;
    end else begin
      col_q      <= col_d;
      row_q      <= row_d;
      out_vld_q  <= out_vld_d;
      out_last_q <= out_last_d;
      out_dat_q  <= out_dat_d;
    end
  end

  always_ff @(posedge pool1_clk) begin
    if (in_fire && !odd_row) linebuf_q[col_q] <= h_dat;
  end

  assign pool1_out_valid_o = out_vld_q;
  assign pool1_out_data_o  = out_dat_q;
  assign pool1_out_last_o  = out_last_q;

endmodule

// File: tb/tb_conv1_maxpool_stage.sv
// Directed bench for conv1_maxpool_stage: frame pooling, negatives, backpressure, mid-frame reset, extremes.
module tb_conv1_maxpool_stage;

  localparam int W   = 22;
  localparam int NF  = 6;
  localparam int PB  = 4;
  localparam int HB  = 2;
  localparam int IB  = NF * PB * W;
  localparam int OB  = NF * HB * W;
  localparam int FS  = 2;
  localparam int MINV = -(1 << 21);
  localparam int MAXV = (1 << 21) - 1;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [IB-1:0] in_data = '0;
  logic          out_valid;
  logic          out_ready = 1'b1;
  logic [OB-1:0] out_data;
  logic          out_last;

  int checks = 0;
  int errors = 0;
  int nout;

  conv1_maxpool_stage dut (
    .pool1_clk        (clk),
    .pool1_rst        (rst),
    .pool1_in_valid_i (in_valid),
    .pool1_in_ready_o (in_ready),
    .pool1_in_data_i  (in_data),
    .pool1_out_valid_o(out_valid),
    .pool1_out_ready_i(out_ready),
    .pool1_out_data_o (out_data),
    .pool1_out_last_o (out_last)
  );

  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [OB-1:0] obs, input logic [OB-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [IB-1:0] frame_beat(input int r, input int b);
    logic [IB-1:0] d;
    d = '0;
    for (int p = 0; p < PB; p++) d[(FS*PB + p)*W +: W] = W'(r*28 + b*4 + p);
    return d;
  endfunction

  function automatic logic [OB-1:0] frame_exp(input int r, input int b);
    logic [OB-1:0] o;
    o = '0;
    for (int k = 0; k < HB; k++) o[(FS*HB + k)*W +: W] = W'(r*28 + b*4 + 2*k + 1);
    return o;
  endfunction

  function automatic logic [IB-1:0] fill_in(input int a, input int b);
    logic [IB-1:0] d;
    d = '0;
    for (int f = 0; f < NF; f++) begin
      for (int k = 0; k < HB; k++) begin
        d[(f*PB + 2*k)*W +: W]     = W'(a);
        d[(f*PB + 2*k + 1)*W +: W] = W'(b);
      end
    end
    return d;
  endfunction

  function automatic logic [OB-1:0] fill_out(input int v);
    logic [OB-1:0] o;
    o = '0;
    for (int i = 0; i < NF*HB; i++) o[i*W +: W] = W'(v);
    return o;
  endfunction

  function automatic int relu(input int v);
`ifdef CONV1_POOL_RELU_EN
    return (v < 0) ? 0 : v;
`else
    return v;
`endif
  endfunction

  // Called at a negedge; returns at the negedge following acceptance.
  task automatic drive_beat(input logic [IB-1:0] d);
    int  t;
    bit  rd;
    in_valid = 1'b1;
    in_data  = d;
    t = 0;
    do begin
      #1 rd = in_ready;
      @(posedge clk);
      @(negedge clk);
      t++;
    end while (!rd && t < 20);
    in_valid = 1'b0;
    chk("accept_wait", OB'(t), OB'(1));
  endtask

  task automatic do_reset();
    rst      = 1'b1;
    in_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("rst_in_ready", OB'(in_ready), '0);
    chk("rst_out_valid", OB'(out_valid), '0);
    chk("rst_out_data", out_data, '0);
    chk("rst_out_last", OB'(out_last), '0);
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_in_ready", OB'(in_ready), OB'(1));
  endtask

  initial begin
    // Full frame, streaming with downstream always ready
    out_ready = 1'b1;
    do_reset();
    nout = 0;
    for (int r = 0; r < 28; r++) begin
      for (int b = 0; b < 7; b++) begin
        drive_beat(frame_beat(r, b));
        if (r % 2 == 1) begin
          if (out_valid) nout++;
          chk($sformatf("t1_valid_r%0d_b%0d", r, b), OB'(out_valid), OB'(1));
          chk($sformatf("t1_data_r%0d_b%0d", r, b), out_data, frame_exp(r, b));
          chk($sformatf("t1_last_r%0d_b%0d", r, b), OB'(out_last), OB'(r == 27 && b == 6));
        end else begin
          chk($sformatf("t1_idle_r%0d_b%0d", r, b), OB'(out_valid), '0);
        end
      end
    end
    chk("t1_beat_count", OB'(nout), OB'(98));
    @(negedge clk);
    chk("t1_drained", OB'(out_valid), '0);

    // Negative data
    do_reset();
    for (int b = 0; b < 7; b++) drive_beat(fill_in(-5, -3));
    drive_beat(fill_in(-7, -1));
    chk("t2_valid", OB'(out_valid), OB'(1));
    chk("t2_data", out_data, fill_out(relu(-1)));

    // Backpressure during an odd row
    do_reset();
    for (int b = 0; b < 7; b++) drive_beat(frame_beat(0, b));
    out_ready = 1'b0;
    drive_beat(frame_beat(1, 0));
    chk("t3_first_valid", OB'(out_valid), OB'(1));
    chk("t3_first_data", out_data, frame_exp(1, 0));
    in_valid = 1'b1;
    in_data  = frame_beat(1, 1);
    for (int i = 0; i < 10; i++) begin
      #1;
      chk($sformatf("t3_stall_rdy_%0d", i), OB'(in_ready), '0);
      chk($sformatf("t3_stall_vld_%0d", i), OB'(out_valid), OB'(1));
      chk($sformatf("t3_stall_dat_%0d", i), out_data, frame_exp(1, 0));
      @(negedge clk);
    end
    out_ready = 1'b1;
    #1 chk("t3_release_rdy", OB'(in_ready), OB'(1));
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    chk("t3_reload_valid", OB'(out_valid), OB'(1));
    chk("t3_reload_data", out_data, frame_exp(1, 1));
    @(negedge clk);
    chk("t3_drained", OB'(out_valid), '0);

    // Reset mid-frame at row 13, col_beat 3 with output pending
    do_reset();
    for (int r = 0; r < 14; r++) begin
      for (int b = 0; b < 7; b++) begin
        if (r < 13 || b <= 3) drive_beat(frame_beat(r, b));
      end
    end
    chk("t5_pending_valid", OB'(out_valid), OB'(1));
    chk("t5_pending_data", out_data, frame_exp(13, 3));
    rst = 1'b1;
    @(negedge clk);
    chk("t5_rst_valid", OB'(out_valid), '0);
    chk("t5_rst_data", out_data, '0);
    chk("t5_rst_ready", OB'(in_ready), '0);
    rst = 1'b0;
    @(negedge clk);
    for (int b = 0; b < 7; b++) drive_beat(fill_in(7, 7));
    chk("t5_row0_idle", OB'(out_valid), '0);
    drive_beat(fill_in(3, 3));
    chk("t5_fresh_valid", OB'(out_valid), OB'(1));
    chk("t5_fresh_data", out_data, fill_out(7));

    // Extremes and ties
    do_reset();
    drive_beat(fill_in(MINV, MAXV));
    for (int b = 1; b < 7; b++) drive_beat(fill_in(MINV, MINV));
    drive_beat(fill_in(MINV, MINV));
    chk("t6_max_valid", OB'(out_valid), OB'(1));
    chk("t6_max_data", out_data, fill_out(MAXV));
    drive_beat(fill_in(MINV, MINV));
    chk("t6_min_data", out_data, fill_out(relu(MINV)));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
